// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display driving one
// shared hex decoder. A double-buffered image is swapped only at frame end.
//
// Parameters:
//   SCAN_DIV  clock cycles per digit slot (>= 4)
//   GUARD     leading cycles per slot with all anodes off (1..SCAN_DIV-1)
//   BLINK_DIV full frames per blink half-period (>= 1)
// Ports:
//   clk, rst_n          clock, async active-low reset
//   load, ready         image load request / buffer free
//   hex_in[15:0]        digit nibbles, [3:0] = digit 0 (rightmost)
//   point_in, en_in,
//   blink_in [3:0]      per-digit point, enable, blink flags
//   seg_hex, seg_point  nibble and point to the decoder
//   seg_le, seg_flash   both carry 'blank' (decoder blanks on LE & flash)
//   an[3:0]             active-low anodes, at most one low
// Options:
//   SEG_LZB_EN          leading-zero blanking on digits 3..1
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int GUARD     = 500,
    parameter int BLINK_DIV = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  en_in,
    input  logic [3:0]  blink_in,
    output logic        ready,
    output logic [3:0]  seg_hex,
    output logic        seg_point,
    output logic        seg_le,
    output logic        seg_flash,
    output logic [3:0]  an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef struct packed {
        logic [15:0] hex;
        logic [3:0]  point;
        logic [3:0]  en;
        logic [3:0]  blink;
    } img_t;

    logic [PW-1:0] pcnt, pcnt_n;
    logic [1:0]    idx, idx_n;
    logic [FW-1:0] fcnt, fcnt_n;
    logic          phase, phase_n;
    logic          pending, pending_n;
    img_t          shadow, shadow_n;
    img_t          active, active_n;

    logic          tick, fb, accept;
    logic [3:0]    lead;
    logic [3:0]    hex_n;
    logic          point_n, blank_n;
    logic [3:0]    an_n;

`ifdef SEG_LZB_EN
    logic [3:1]    zero;
`endif

    always_comb begin
        tick    = (pcnt == PW'(SCAN_DIV - 1));
        fb      = tick && (idx == 2'd3);
        accept  = load && !pending;

        pcnt_n  = tick ? '0 : pcnt + 1'b1;
        idx_n   = tick ? idx + 2'd1 : idx;

        fcnt_n  = fcnt;
        phase_n = phase;
        if (fb) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
                fcnt_n  = '0;
                phase_n = !phase;
            end else begin
                fcnt_n = fcnt + 1'b1;
            end
        end

        // A load accepted on the fb cycle sees pending=0 there, so it
        // naturally waits for the following frame boundary.
        active_n  = (fb && pending) ? shadow : active;
        pending_n = accept | (pending & !fb);
        shadow_n  = accept ? img_t'{hex_in, point_in, en_in, blink_in}
                           : shadow;

`ifdef SEG_LZB_EN
        for (int j = 1; j < 4; j++) begin
            zero[j] = (active_n.hex[4*j +: 4] == 4'd0) && !active_n.point[j];
        end
        lead = {zero[3], &zero[3:2], &zero[3:1], 1'b0};
`else
        lead = 4'b0000;
`endif

        // Outputs are computed from next-state values so they change on
        // the same edge as pcnt/idx and the image swap.
        hex_n   = active_n.hex[{idx_n, 2'b00} +: 4];
        point_n = active_n.point[idx_n];
        blank_n = !active_n.en[idx_n]
                | (active_n.blink[idx_n] & phase_n)
                | lead[idx_n];
        an_n    = (pcnt_n < PW'(GUARD)) ? 4'b1111
                                        : ~(4'b0001 << idx_n);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt      <= '0;
            idx       <= 2'd0;
            fcnt      <= '0;
            phase     <= 1'b0;
            pending   <= 1'b0;
            shadow    <= '0;
            active    <= '0;
            ready     <= 1'b1;
            seg_hex   <= 4'd0;
            seg_point <= 1'b0;
            seg_le    <= 1'b1;
            seg_flash <= 1'b1;
            an        <= 4'b1111;
        end else begin
            pcnt      <= pcnt_n;
            idx       <= idx_n;
            fcnt      <= fcnt_n;
            phase     <= phase_n;
            pending   <= pending_n;
            shadow    <= shadow_n;
            active    <= active_n;
            ready     <= !pending_n;
            seg_hex   <= hex_n;
            seg_point <= point_n;
            seg_le    <= blank_n;
            seg_flash <= blank_n;
            an        <= an_n;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexing scan controller for a 4-digit common-anode seven-segment display built around a single shared hex-to-segment decoder. It holds a double-buffered display image (four nibbles with per-digit point, enable and blink flags), selects one digit per scan slot, and drives the decoder's hex, point, LE and flash inputs plus the digit anodes. A load handshake lets the host update the image without tearing mid-frame.

## Interface
- `SCAN_DIV`, 50000: clock cycles per digit slot (≥ 4).
- `GUARD`, 500: cycles at the start of each slot with all anodes off (anti-ghosting). Must satisfy 1 ≤ `GUARD` < `SCAN_DIV`.
- `BLINK_DIV`, 64: full frames per blink half-period (≥ 1).

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `load` in 1: request to capture a new display image.
- `hex_in` in 16: digit nibbles; `[3:0]` is digit 0 (rightmost).
- `point_in` in 4: decimal point per digit, 1 = lit.
- `en_in` in 4: digit enable, 1 = shown.
- `blink_in` in 4: 1 = digit blinks.
- `ready` out 1: image buffer can accept `load`.
- `seg_hex` out 4: nibble to the decoder.
- `seg_point` out 1: point to the decoder.
- `seg_le` out 1: decoder LE input.
- `seg_flash` out 1: decoder flash input. The decoder blanks when LE & flash; both outputs carry the same `blank` value.
- `an` out 4: digit anodes, active-low, at most one low.

## Operation
- Registers: prescaler `pcnt` (0..`SCAN_DIV`-1), digit index `idx` (0..3), frame counter `fcnt` (0..`BLINK_DIV`-1), `phase` (blink on/off), shadow image, active image, `pending`.
- `tick` = (`pcnt` == `SCAN_DIV`-1). `pcnt` wraps to 0 on `tick`. `idx` increments mod 4 on `tick`.
- Frame boundary `fb` = `tick` & (`idx` == 3). On `fb`: `fcnt` increments and wraps; on wrap, `phase` toggles.
- Per-slot output, from the active image at `idx`:
  - `seg_hex` = nibble.
  - `seg_point` = point bit.
  - `blank` = !en | (blink & `phase`).
  - `an` = all ones while `pcnt` < `GUARD`, else bit `idx` low.
- Handshake:
  - `load` & `ready` captures all inputs into shadow and sets `pending`; `ready` = !`pending`.
  - On `fb` with `pending`: active ← shadow, `pending` clears.
  - `load` while `ready`=0 is ignored (no queueing).
  - `load` accepted in the same cycle as `fb`: it is not transferred by that `fb`; it transfers at the next `fb`.
- Reset values:
  - `pcnt`=0, `idx`=0, `fcnt`=0, `phase`=0, `pending`=0.
  - Shadow and active images all zero, so every digit is disabled.
  - Outputs: `ready`=1, `an`=4'b1111, `seg_hex`=0, `seg_point`=0, `seg_le`=`seg_flash`=1.
- Reset mid-frame or mid-transfer: immediate return to reset state; any captured shadow is discarded.

## Timing
- All outputs are registered and update on the same edge that changes `pcnt`/`idx`, so there is no combinational path from inputs to outputs.
- Slot i: `an` all high for `GUARD` cycles, then bit i low for `SCAN_DIV`-`GUARD` cycles.
- `seg_hex`, `seg_point` and `blank` change exactly at slot start, while the anodes are still off.
- `ready` falls the cycle after acceptance. It rises the cycle after the transferring `fb`.
- New image first shown in the slot-0 that follows the transfer.
- Load-to-ready worst case: 4·`SCAN_DIV` cycles.

## Configuration
- `SEG_LZB_EN` defined: leading-zero blanking.
  - Digit k (k = 3..1) is additionally blanked when nibbles k..3 are all 0 and `point_in` bits k..3 are all 0.
  - Digit 0 is never blanked by this rule.
  - Evaluated on the active image.
- `SEG_LZB_EN` undefined: zeros are displayed; `blank` depends on enable/blink only.

## Test plan
Bench parameters: `SCAN_DIV`=8, `GUARD`=2, `BLINK_DIV`=2.
- **Reset:** assert `rst_n`=0 mid-slot → next sampling shows `an`=1111, `seg_le`=`seg_flash`=1, `ready`=1, `seg_hex`=0; after release, first digit-0 anode goes low at cycle 2.
- **Scan:** load `hex_in`=16'h1234, `en_in`=1111, `point_in`=0100, `blink_in`=0 → after transfer, slots show `an`=1110/1101/1011/0111 with `seg_hex`=4/3/2/1, `seg_point`=1 only on digit 2, `an`=1111 for 2 cycles per slot.
- **Handshake:** pulse `load` with 16'hAAAA, then `load` with 16'h5555 while `ready`=0 → second ignored; display shows A on all digits; `ready` returns high one cycle after `fb`. `load` on the `fb` cycle → transferred one frame later.
- **Blink:** `blink_in`=0001 → digit 0 `blank`=0 for 2 frames, 1 for 2 frames, repeating; other digits unaffected.
- **Disable:** `en_in`=1010 → `blank`=1 in slots 0 and 2, anodes still scanned.
- **LZB (`SEG_LZB_EN`):** `hex_in`=16'h0070, `point_in`=0 → digits 3 and 2 blank, digits 1 and 0 shown as 7 and 0. With `point_in`=1000 → no digits blanked. Without the macro → all four shown.
